// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM states,
// default operand width and the signed-overflow check.
package serial_arith_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Subtraction overflows when operand signs differ and the result sign
  // departs from the minuend; addition is the same test with b's sign flipped.
  function automatic logic signed_ovf(input logic a_msb,
                                      input logic b_msb,
                                      input logic r_msb,
                                      input logic is_sub);
    logic b_eff;
    b_eff = is_sub ? ~b_msb : b_msb;
    return (a_msb == b_eff) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: a - b - bin, LSB first, one bit
// per clock through a single full_subtractor cell, start/busy/done handshake.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned     CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] r_sr;
  logic [WIDTH-1:0] r_cat;
  logic [CW-1:0]    cnt;
  logic             borrow, a_msb, b_msb;
  logic             load, last;
  logic             d_cell, bout_cell;

  full_subtractor u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow),
    .d    (d_cell),
    .bout (bout_cell)
  );

  // r_sr holds the WIDTH-1 bits already produced; the current cell output
  // completes the word, so the final result is taken from r_cat directly.
  assign r_cat = {d_cell, r_sr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    load     = 1'b0;
    last     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == LAST) begin
          last     = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (load) begin
      a_sr   <= a;
      b_sr   <= b;
      borrow <= bin;
      cnt    <= '0;
      a_msb  <= a[WIDTH-1];
      b_msb  <= b[WIDTH-1];
    end else if (state == SHIFT) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      r_sr   <= r_cat[WIDTH-1:1];
      borrow <= bout_cell;
      cnt    <= cnt + CW'(1);
      if (last) begin
        diff <= r_cat;
        bout <= bout_cell;
        ovf  <= signed_ovf(a_msb, b_msb, d_cell, 1'b1);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: transaction-level reference model
// compared every cycle, plus directed vectors with hand-computed results.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk, rst_n, start, bin;
  logic [W-1:0] a, b;
  logic         busy, done, bout, ovf;
  logic [W-1:0] diff;

  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: an accepted request keeps the block busy for W+1 cycles,
  // the last of which is the done cycle where the arithmetic result appears.
  int           m_left = 0;
  logic [W-1:0] m_diff = '0, p_diff;
  logic         m_bout = 1'b0, m_ovf = 1'b0, p_bout, p_ovf;
  int           sa, sb, sr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_diff = '0;
      m_bout = 1'b0;
      m_ovf  = 1'b0;
    end else if (m_left == 0) begin
      if (start) begin
        m_left = W + 1;
        p_diff = a - b - W'(bin);
        p_bout = (int'(a) < int'(b) + int'(bin));
        sa     = int'(a) - (a[W-1] ? (1 << W) : 0);
        sb     = int'(b) - (b[W-1] ? (1 << W) : 0);
        sr     = sa - sb - int'(bin);
        p_ovf  = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
      end
    end else begin
      m_left = m_left - 1;
      if (m_left == 1) begin
        m_diff = p_diff;
        m_bout = p_bout;
        m_ovf  = p_ovf;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("cycle busy", busy, m_left != 0);
      chk("cycle done", done, m_left == 1);
      chk("cycle diff", diff, m_diff);
      chk("cycle bout", bout, m_bout);
      chk("cycle ovf",  ovf,  m_ovf);
    end
  end

  task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tbin, input logic [W-1:0] ediff,
                        input logic ebout, input logic eovf);
    int busy_n, done_n, done_at;
    busy_n  = 0;
    done_n  = 0;
    done_at = -1;
    @(posedge clk); #2;
    a = ta; b = tb_v; bin = tbin; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    for (int i = 0; i < W + 5; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        done_at = i;
      end
    end
    chk({name, " busy cycles"}, busy_n, W + 1);
    chk({name, " done pulses"}, done_n, 1);
    chk({name, " done position"}, done_at, W);
    chk({name, " diff"}, diff, ediff);
    chk({name, " bout"}, bout, ebout);
    chk({name, " ovf"},  ovf,  eovf);
    chk({name, " model diff"}, m_diff, ediff);
    chk({name, " model bout"}, m_bout, ebout);
    chk({name, " model ovf"},  m_ovf,  eovf);
  endtask

  initial begin
    int  dones;
    bit  seen;
    rst_n = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset diff", diff, 0);
    chk("reset bout", bout, 0);
    chk("reset ovf",  ovf,  0);
    #20;
    @(negedge clk) rst_n = 1'b1;
    check_en = 1'b1;

    run_op("nominal",      8'd200, 8'd55,  1'b0, 8'h91, 1'b0, 1'b0);
    run_op("negative",     8'd5,   8'd9,   1'b0, 8'hFC, 1'b1, 1'b0);
    run_op("ovf neg",      8'h80,  8'h01,  1'b0, 8'h7F, 1'b0, 1'b1);
    run_op("ovf pos",      8'h7F,  8'hFF,  1'b0, 8'h80, 1'b1, 1'b1);
    run_op("bin wrap",     8'h00,  8'h00,  1'b1, 8'hFF, 1'b1, 1'b0);
    run_op("zero",         8'h00,  8'h00,  1'b0, 8'h00, 1'b0, 1'b0);
    run_op("bin ovf",      8'h80,  8'h00,  1'b1, 8'h7F, 1'b0, 1'b1);

    // Start while busy: requests in SHIFT and DONE ignored, the one held into IDLE accepted.
    dones = 0;
    @(posedge clk); #2;
    a = 8'd10; b = 8'd3; bin = 1'b0; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0; a = W'($urandom); b = W'($urandom);
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #2;
      if (done) begin
        dones++;
        chk("busy-start first diff", diff, 7);
      end
      if (e == 3 || e == 8) begin
        start = 1'b1; a = 8'd99; b = 8'd1; bin = 1'b0;
      end else if (e == 4 || e == 10) begin
        start = 1'b0;
      end
    end
    chk("busy-start done pulses", dones, 1);
    seen = 1'b0;
    for (int i = 0; i < W + 5; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        chk("back-to-back diff", diff, 98);
      end
    end
    chk("back-to-back done seen", seen, 1);

    // Asynchronous reset in the middle of an operation.
    @(posedge clk); #2;
    a = 8'd200; b = 8'd55; bin = 1'b0; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    chk("pre-reset busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid reset busy", busy, 0);
    chk("mid reset done", done, 0);
    chk("mid reset diff", diff, 0);
    chk("mid reset bout", bout, 0);
    chk("mid reset ovf",  ovf,  0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    run_op("after reset", 8'd1, 8'd2, 1'b0, 8'hFF, 1'b1, 1'b0);

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
